// File: rtl/audio_nios_led_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// audio_nios_led_alarm_ctrl
//
// Sequencer/arbiter in front of the 4-bit LED PIO slave (s1). Software LED
// updates arrive on the host port. The alarm blink engine takes over the PIO
// while alarm_active is high. It alternates the LEDs between alarm_pattern and
// all-off every BLINK_DIV clocks. When the alarm clears, the last host value
// is written back.
//
// Ports
//   clk, reset_n     : system clock (rising edge), async active-low reset
//   alarm_active     : level request for alarm mode
//   alarm_pattern    : LED value for the blink on-phase
//   host_write       : 1-cycle strobe, host LED update request
//   host_writedata   : LED value accompanying host_write
//   pio_address      : PIO s1 address (always 0)
//   pio_chipselect   : PIO s1 chipselect, 1-cycle pulse per write
//   pio_write_n      : PIO s1 write strobe, always ~pio_chipselect
//   pio_writedata    : PIO s1 data, {28'b0, value}
//   led_shadow       : last accepted host value
//   alarm_mode       : 1 while the blink engine owns the PIO
// ---------------------------------------------------------------------------
module audio_nios_led_alarm_ctrl #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNT_W     = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alarm_active,
  input  logic [3:0]  alarm_pattern,
  input  logic        host_write,
  input  logic [3:0]  host_writedata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic [3:0]  led_shadow,
  output logic        alarm_mode
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ALARM = 1'b1
  } state_t;

  localparam logic             PH_OFF   = 1'b0;
  localparam logic             PH_ON    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             phase_r, phase_s;
  logic             mode_r, mode_s;
  logic             cs_r, cs_s;
  logic [3:0]       wd_r, wd_s;
  logic [3:0]       shadow_r, shadow_s;

  // Next-state, blink sequencing and PIO write selection.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    phase_s = phase_r;
    mode_s  = mode_r;
    cs_s    = 1'b0;
    wd_s    = wd_r;

    // Host writes always land in the shadow, whatever the engine is doing.
    if (host_write) begin
      shadow_s = host_writedata;
    end else begin
      shadow_s = shadow_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (alarm_active) begin
          // Alarm entry beats a coincident host write on the PIO.
          state_s = ST_ALARM;
          cnt_s   = CNT_ZERO;
          phase_s = PH_ON;
          mode_s  = 1'b1;
          cs_s    = 1'b1;
          wd_s    = alarm_pattern;
        end else if (host_write) begin
          cs_s = 1'b1;
          wd_s = host_writedata;
        end else begin
          cs_s = 1'b0;
        end
      end
      ST_ALARM: begin
        if (!alarm_active) begin
          // Restore has priority over a coincident blink toggle. A host write
          // in the same cycle is bypassed straight to the restore data.
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          phase_s = PH_OFF;
          mode_s  = 1'b0;
          cs_s    = 1'b1;
          wd_s    = shadow_s;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s   = CNT_ZERO;
          phase_s = ~phase_r;
          cs_s    = 1'b1;
          if (phase_r == PH_OFF) begin
            wd_s = alarm_pattern;
          end else begin
            wd_s = 4'h0;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        phase_s = PH_OFF;
        mode_s  = 1'b0;
        cs_s    = 1'b0;
      end
    endcase
  end

  // State and registered PIO/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      phase_r  <= PH_OFF;
      mode_r   <= 1'b0;
      cs_r     <= 1'b0;
      wd_r     <= 4'h0;
      shadow_r <= 4'h0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      phase_r  <= phase_s;
      mode_r   <= mode_s;
      cs_r     <= cs_s;
      wd_r     <= wd_s;
      shadow_r <= shadow_s;
    end
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = cs_r;
  assign pio_write_n    = ~cs_r;
  assign pio_writedata  = {28'h0000000, wd_r};
  assign led_shadow     = shadow_r;
  assign alarm_mode     = mode_r;

endmodule

// File: tb/tb_audio_nios_led_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_audio_nios_led_alarm_ctrl
//
// Self-checking bench for audio_nios_led_alarm_ctrl with BLINK_DIV=4.
// The reference model tracks the alarm mode, the cycles elapsed since alarm
// entry and the host shadow. It derives every expected PIO write from those
// quantities with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_audio_nios_led_alarm_ctrl;

  localparam int DIV = 4;

  logic        clk;
  logic        reset_n;
  logic        alarm_active;
  logic [3:0]  alarm_pattern;
  logic        host_write;
  logic [3:0]  host_writedata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [3:0]  led_shadow;
  logic        alarm_mode;

  audio_nios_led_alarm_ctrl #(.BLINK_DIV(DIV), .CNT_W(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .alarm_active   (alarm_active),
    .alarm_pattern  (alarm_pattern),
    .host_write     (host_write),
    .host_writedata (host_writedata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .led_shadow     (led_shadow),
    .alarm_mode     (alarm_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic       m_mode;
  int         m_elapsed;
  logic [3:0] m_shadow;
  logic       m_cs;
  logic [3:0] m_wd;
  int         n_writes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 1'b0;
    m_elapsed = 0;
    m_shadow  = 4'h0;
    m_cs      = 1'b0;
    m_wd      = 4'h0;
  endtask

  // Model of one rising edge given the inputs currently applied.
  task automatic model_edge();
    logic [3:0] new_shadow;
    new_shadow = host_write ? host_writedata : m_shadow;
    m_cs = 1'b0;
    if (!m_mode) begin
      if (alarm_active) begin
        m_mode = 1'b1; m_elapsed = 0; m_cs = 1'b1; m_wd = alarm_pattern;
      end else if (host_write) begin
        m_cs = 1'b1; m_wd = host_writedata;
      end
    end else begin
      if (!alarm_active) begin
        m_mode = 1'b0; m_cs = 1'b1; m_wd = new_shadow;
      end else begin
        m_elapsed++;
        if (m_elapsed % DIV == 0) begin
          m_cs = 1'b1;
          m_wd = ((m_elapsed / DIV) % 2 == 0) ? alarm_pattern : 4'h0;
        end
      end
    end
    m_shadow = new_shadow;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cs"},     {31'b0, pio_chipselect}, {31'b0, m_cs});
    check({tag, ".wr_n"},   {31'b0, pio_write_n},    {31'b0, ~m_cs});
    check({tag, ".addr"},   {30'b0, pio_address},    32'h0);
    check({tag, ".shadow"}, {28'b0, led_shadow},     {28'b0, m_shadow});
    check({tag, ".mode"},   {31'b0, alarm_mode},     {31'b0, m_mode});
    if (m_cs) begin
      check({tag, ".wdata"}, pio_writedata, {28'b0, m_wd});
    end
  endtask

  // Apply inputs, take one clock edge, check outputs 1 time unit later.
  task automatic step(input string tag, input logic al, input logic [3:0] pat,
                      input logic hw, input logic [3:0] hwd);
    alarm_active   = al;
    alarm_pattern  = pat;
    host_write     = hw;
    host_writedata = hwd;
    @(posedge clk);
    model_edge();
    #1;
    if (pio_chipselect === 1'b1) n_writes++;
    compare_all(tag);
  endtask

  initial begin
    logic al;
    reset_n = 1'b0; alarm_active = 1'b0; alarm_pattern = 4'h0;
    host_write = 1'b0; host_writedata = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    reset_n = 1'b1;

    // 1: idle after reset, no writes
    n_writes = 0;
    for (int i = 0; i < 10; i++) step("idle", 1'b0, 4'h0, 1'b0, 4'h0);
    check("idle_no_write", n_writes, 32'd0);

    // 2: host write
    step("host_A", 1'b0, 4'h0, 1'b1, 4'hA);
    check("host_A_data", pio_writedata, 32'h0000000A);
    step("host_gap", 1'b0, 4'h0, 1'b0, 4'h0);

    // 3: alarm rise with pattern F, blink through F,0,F
    n_writes = 0;
    for (int i = 0; i < 9; i++) step("blink", 1'b1, 4'hF, 1'b0, 4'h0);
    check("blink_writes", n_writes, 32'd3);

    // 4: host write during alarm, then fall -> restore 3
    step("alarm_host", 1'b1, 4'hF, 1'b1, 4'h3);
    step("restore", 1'b0, 4'hF, 1'b0, 4'h0);
    check("restore_data", pio_writedata, 32'h00000003);

    // 5: fall exactly on the toggle cycle
    step("rise2", 1'b1, 4'h5, 1'b0, 4'h0);
    for (int i = 0; i < DIV - 1; i++) step("count", 1'b1, 4'h5, 1'b0, 4'h0);
    n_writes = 0;
    step("fall_toggle", 1'b0, 4'h5, 1'b0, 4'h0);
    step("after_fall", 1'b0, 4'h5, 1'b0, 4'h0);
    check("fall_toggle_writes", n_writes, 32'd1);

    // fall + host write bypass, then immediate reassert
    step("rise3", 1'b1, 4'h9, 1'b1, 4'h1);
    step("fall_host", 1'b0, 4'h9, 1'b1, 4'h6);
    step("reassert", 1'b1, 4'hC, 1'b0, 4'h0);

    // 6: async reset mid-alarm
    step("pre_rst", 1'b1, 4'hC, 1'b0, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    alarm_active = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_writes = 0;
    for (int i = 0; i < 6; i++) step("post_rst", 1'b0, 4'hC, 1'b0, 4'h0);
    check("post_rst_writes", n_writes, 32'd0);

    // randomized traffic against the model
    al = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) al = ~al;
      step("rand", al, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
